// File: rtl/axi_mem_responder_if.sv
// AXI4 link bundle between an initiator (or register slice) and a responder.
// The master modport is the terminating view used by axi_mem_responder: it
// samples request channels and drives ready/response signals.
interface axi_bus_t;
  logic         awvalid;
  logic         awready;
  logic [15:0]  awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;

  logic         wvalid;
  logic         wready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;

  logic         bvalid;
  logic         bready;
  logic [15:0]  bid;
  logic [1:0]   bresp;

  logic         arvalid;
  logic         arready;
  logic [15:0]  arid;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;

  logic         rvalid;
  logic         rready;
  logic [15:0]  rid;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         ruser;

  modport master (
    input  awvalid, awid, awaddr, awlen, awsize,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize,
    output arready,
    output rvalid, rid, rdata, rresp, rlast, ruser,
    input  rready
  );

  modport slave (
    output awvalid, awid, awaddr, awlen, awsize,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast, ruser,
    output rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 responder backed by a 512-bit-wide on-chip memory. Independent write
// and read FSMs, each serving one INCR burst at a time.
module axi_mem_responder #(
  parameter int unsigned LOG_DEPTH = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  axi_bus_t.master axi_s
);

  localparam int unsigned DEPTH = 2 ** LOG_DEPTH;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic     init_q;

  // Word pointers carry addr[63:6] plus one spare bit so a burst running past
  // the top of the 64-bit space reads as out of range instead of wrapping.
  logic [58:0]  w_ptr, r_ptr;
  logic [7:0]   w_len, w_beat, r_len, r_beat;
  logic [15:0]  w_id, r_id;
  logic         w_err;
  logic [511:0] mem [DEPTH];
  logic [511:0] mem_q;

  logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic aw_hs, w_hs, ar_hs, r_hs;
  logic w_in_range, r_in_range, w_last_beat, r_last_beat;
  logic unused_ok;

  assign w_in_range  = (w_ptr >> LOG_DEPTH) == '0;
  assign r_in_range  = (r_ptr >> LOG_DEPTH) == '0;
  assign w_last_beat = (w_beat == w_len);
  assign r_last_beat = (r_beat == r_len);

  assign aw_hs = aw_rdy & axi_s.awvalid;
  assign w_hs  = w_rdy  & axi_s.wvalid;
  assign ar_hs = ar_rdy & axi_s.arvalid;
  assign r_hs  = r_vld  & axi_s.rready;

  // Ready-gating flop: sets on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end

  // FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Write FSM next state and channel handshake outputs.
  always_comb begin
    w_next = w_state;
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    b_vld  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        aw_rdy = init_q;
        if (init_q && axi_s.awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (axi_s.wvalid && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (axi_s.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read FSM next state and channel handshake outputs.
  always_comb begin
    r_next = r_state;
    ar_rdy = 1'b0;
    r_vld  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        ar_rdy = init_q;
        if (init_q && axi_s.arvalid) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        r_vld = 1'b1;
        if (axi_s.rready) r_next = r_last_beat ? R_IDLE : R_FETCH;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Write burst bookkeeping: captured id/length, word pointer, error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_id   <= '0;
      w_ptr  <= '0;
      w_len  <= '0;
      w_beat <= '0;
      w_err  <= 1'b0;
    end else if (aw_hs) begin
      w_id   <= axi_s.awid;
      w_ptr  <= {1'b0, axi_s.awaddr[63:6]};
      w_len  <= axi_s.awlen;
      w_beat <= '0;
      w_err  <= 1'b0;
    end else if (w_hs) begin
      w_ptr  <= w_ptr + 59'd1;
      w_beat <= w_beat + 8'd1;
      if (!w_in_range || (axi_s.wlast != w_last_beat)) w_err <= 1'b1;
    end
  end

  // Read burst bookkeeping: captured id/length and word pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id   <= '0;
      r_ptr  <= '0;
      r_len  <= '0;
      r_beat <= '0;
    end else if (ar_hs) begin
      r_id   <= axi_s.arid;
      r_ptr  <= {1'b0, axi_s.araddr[63:6]};
      r_len  <= axi_s.arlen;
      r_beat <= '0;
    end else if (r_hs) begin
      r_ptr  <= r_ptr + 59'd1;
      r_beat <= r_beat + 8'd1;
    end
  end

  // Memory: byte-strobed write port, read-first synchronous read port. The
  // read register only loads in R_FETCH, so rdata holds while R_DATA stalls.
  always_ff @(posedge clk) begin
    if (w_hs && w_in_range) begin
      for (int unsigned i = 0; i < 64; i++) begin
        if (axi_s.wstrb[i]) mem[w_ptr[LOG_DEPTH-1:0]][i*8 +: 8] <= axi_s.wdata[i*8 +: 8];
      end
    end
    if (r_state == R_FETCH) mem_q <= mem[r_ptr[LOG_DEPTH-1:0]];
  end

  assign axi_s.awready = aw_rdy;
  assign axi_s.wready  = w_rdy;
  assign axi_s.bvalid  = b_vld;
  assign axi_s.bid     = w_id;
  assign axi_s.bresp   = (b_vld && w_err) ? 2'b10 : 2'b00;
  assign axi_s.arready = ar_rdy;
  assign axi_s.rvalid  = r_vld;
  assign axi_s.rid     = r_id;
  assign axi_s.rdata   = (r_vld && r_in_range) ? mem_q : '0;
  assign axi_s.rresp   = (r_vld && !r_in_range) ? 2'b10 : 2'b00;
  assign axi_s.rlast   = r_vld && r_last_beat;
  assign axi_s.ruser   = 1'b0;

  assign unused_ok = ^{axi_s.awaddr[5:0], axi_s.araddr[5:0], axi_s.awsize, axi_s.arsize};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a memory model and B/R scoreboards.
module tb_axi_mem_responder;

  localparam int unsigned LOG_DEPTH = 10;
  localparam int unsigned DEPTH     = 2 ** LOG_DEPTH;
  localparam int unsigned LIMIT     = 200;

  typedef struct {
    logic [15:0] id;
    logic [1:0]  resp;
  } b_exp_t;

  typedef struct {
    logic [15:0]  id;
    logic [511:0] data;
    logic [1:0]   resp;
    logic         last;
  } r_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [511:0] model [DEPTH];
  b_exp_t       bq [$];
  r_exp_t       rq [$];

  axi_bus_t axi ();

  axi_mem_responder #(.LOG_DEPTH(LOG_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axi_s (axi)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len);
    int unsigned n = 0;
    @(negedge clk);
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd6;
    axi.awvalid = 1'b1;
    while (!axi.awready && n < LIMIT) begin @(negedge clk); n++; end
    chk("aw_wait", n < LIMIT, 1'b1);
    @(negedge clk);
    axi.awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len);
    int unsigned n = 0;
    @(negedge clk);
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd6;
    axi.arvalid = 1'b1;
    while (!axi.arready && n < LIMIT) begin @(negedge clk); n++; end
    chk("ar_wait", n < LIMIT, 1'b1);
    @(negedge clk);
    axi.arvalid = 1'b0;
  endtask

  task automatic recv_b();
    b_exp_t      e;
    int unsigned n = 0;
    @(negedge clk);
    chk("bvalid_hold", axi.bvalid, 1'b1);
    axi.bready = 1'b1;
    while (!axi.bvalid && n < LIMIT) begin @(negedge clk); n++; end
    chk("b_wait", n < LIMIT, 1'b1);
    e = bq.pop_front();
    chk("bid", axi.bid, e.id);
    chk("bresp", axi.bresp, e.resp);
    @(negedge clk);
    axi.bready = 1'b0;
    chk("awready_after_b", axi.awready, 1'b1);
  endtask

  task automatic write_burst(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [511:0] pat, input logic [63:0] strb, input bit bad_last);
    bit           err;
    int unsigned  word;
    int unsigned  n;
    logic [511:0] d;
    err = bad_last;
    send_aw(id, addr, len);
    chk("wready_after_aw", axi.wready, 1'b1);
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      d = pat ^ 512'(i);
      axi.wvalid = 1'b1; axi.wdata = d; axi.wstrb = strb;
      axi.wlast = (i == 32'(len)) ^ (bad_last && i == 0);
      n = 0;
      while (!axi.wready && n < LIMIT) begin @(negedge clk); n++; end
      chk("w_wait", n < LIMIT, 1'b1);
      @(posedge clk);
      word = 32'(addr >> 6) + i;
      if (word < DEPTH) begin
        for (int unsigned b = 0; b < 64; b++)
          if (strb[b]) model[word][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        err = 1'b1;
      end
      @(negedge clk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    chk("bvalid_after_last_w", axi.bvalid, 1'b1);
    bq.push_back('{id, err ? 2'b10 : 2'b00});
    recv_b();
  endtask

  task automatic read_burst(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input bit rand_rdy);
    r_exp_t      e;
    int unsigned n = 0;
    int unsigned word;
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      word = 32'(addr >> 6) + i;
      if (word < DEPTH) rq.push_back('{id, model[word], 2'b00, i == 32'(len)});
      else              rq.push_back('{id, '0, 2'b10, i == 32'(len)});
    end
    send_ar(id, addr, len);
    chk("rvalid_ar_plus1", axi.rvalid, 1'b0);
    @(negedge clk);
    chk("rvalid_ar_plus2", axi.rvalid, 1'b1);
    while (rq.size() > 0 && n < 5000) begin
      axi.rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi.rvalid && axi.rready) begin
        e = rq.pop_front();
        chk("rid", axi.rid, e.id);
        chk("rdata", axi.rdata, e.data);
        chk("rresp", axi.rresp, e.resp);
        chk("rlast", axi.rlast, e.last);
      end else if (axi.rvalid) begin
        chk("rdata_hold", axi.rdata, rq[0].data);
      end
      @(negedge clk);
      n++;
    end
    chk("r_remaining", rq.size(), 0);
    axi.rready = 1'b0;
    chk("arready_after_r", axi.arready, 1'b1);
  endtask

  initial begin
    axi.awvalid = 1'b0; axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0;
    axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
    axi.bready = 1'b0;
    axi.arvalid = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
    axi.rready = 1'b0;

    // Reset and release.
    repeat (5) @(negedge clk);
    chk("reset_ctl", {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid,
                      axi.bid, axi.bresp, axi.rid, axi.rresp, axi.rlast, axi.ruser}, '0);
    chk("reset_rdata", axi.rdata, '0);
    rst_n = 1'b1;
    chk("ready_at_release", {axi.awready, axi.arready}, 2'b00);
    @(negedge clk);
    chk("ready_after_release", {axi.awready, axi.arready}, 2'b11);

    // Single beat write then read at 0x40.
    write_burst(16'h1234, 64'h40, 8'd0, {64{8'hA5}}, '1, 1'b0);
    read_burst(16'h4321, 64'h40, 8'd0, 1'b0);

    // Byte strobes on word 3.
    write_burst(16'h0003, 64'd192, 8'd0, {64{8'hFF}}, '1, 1'b0);
    write_burst(16'h0004, 64'd192, 8'd0, '0, 64'h0000_0000_0000_00F0, 1'b0);
    read_burst(16'h0005, 64'd192, 8'd0, 1'b0);

    // 256-beat burst, random rready on the read.
    write_burst(16'h000A, 64'h0, 8'd255, '0, '1, 1'b0);
    read_burst(16'h000B, 64'h0, 8'd255, 1'b1);

    // Burst crossing the top of memory.
    write_burst(16'h000E, 64'd1022 * 64, 8'd3, {64{8'h3C}}, '1, 1'b0);
    read_burst(16'h000F, 64'd1022 * 64, 8'd3, 1'b0);

    // wlast on the wrong beat.
    write_burst(16'h0006, 64'h800, 8'd1, {64{8'h5A}}, '1, 1'b1);

    // Overlapping write and read bursts.
    fork
      write_burst(16'h0077, 64'd100 * 64, 8'd3, {64{8'h96}}, '1, 1'b0);
      read_burst(16'h0055, 64'h40, 8'd3, 1'b1);
    join

    // Reset while a read beat is pending.
    send_ar(16'h0066, 64'h40, 8'd0);
    @(negedge clk);
    chk("rvalid_before_reset", axi.rvalid, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("rvalid_in_reset", {axi.rvalid, axi.arready}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_burst(16'h0067, 64'h40, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 responder (slave end) backed by an on-chip memory of 512-bit words. It terminates an `axi_bus_t` link driven by an initiator or by a register slice, accepts INCR write and read bursts, and returns B and R responses. Read and write paths are independent, each handling one burst at a time. It serves as a local scratchpad and as the far-end model for benches exercising the AXI pipeline stages.

## Interface
- `LOG_DEPTH`, default 10: memory holds 2^LOG_DEPTH 64-byte words (64 KiB at the default).
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `axi_s`  `axi_bus_t.master` modport  —  upstream link; this block is the responder on it.
  - Fields used: aw{valid,ready,id[15:0],addr[63:0],len[7:0],size[2:0]}, w{valid,ready,data[511:0],strb[63:0],last}, b{valid,ready,id[15:0],resp[1:0]}, ar{valid,ready,id,addr,len,size}, r{valid,ready,id[15:0],data[511:0],resp[1:0],last,user}.

## Operation
- Addressing:
  - Word index = addr[6 +: LOG_DEPTH].
  - addr[5:0] ignored; awsize/arsize ignored (every beat is 64 bytes); burst type is always INCR.
  - A beat is in range iff its byte address (start + 64·beat, 64-bit arithmetic, no wrap) < 2^(LOG_DEPTH+6).
- Write FSM, states W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: awready=1. On awvalid, capture awid, start word, and awlen; clear the error flag.
  - W_DATA: wready=1.
    - Each handshake writes data with per-byte strobes if the beat is in range; otherwise the beat is dropped and the error flag is set.
    - Then the word pointer increments.
    - Leave the state on the beat where the counter reaches awlen. wlast is not used to terminate the burst.
    - If wlast disagrees with the beat count, set the error flag.
  - W_RESP: bvalid=1, bid=captured awid, bresp=2'b10 (SLVERR) if the error flag is set, else 2'b00. Hold until bready.
- Read FSM, states R_IDLE → R_FETCH → R_DATA:
  - R_IDLE: arready=1. On arvalid, capture arid, start word, and arlen.
  - R_FETCH: issue the synchronous memory read. Go to R_DATA next cycle.
  - R_DATA: rvalid=1, rid=captured arid, rlast=(beat==arlen), ruser=0.
    - rdata = memory word, or 0 if out of range.
    - rresp = 2'b10 if out of range, else 2'b00.
    - Hold all R fields stable until rready.
    - On handshake: last beat → R_IDLE; otherwise → R_FETCH.
- Memory: one write port and one read port; contents are not reset.
- Same-cycle read and write to the same word: read returns old data (read-first).

## Timing
- Reset values while rst_n=0:
  - awready=0, wready=0, bvalid=0, arready=0, rvalid=0.
  - bid, bresp, rid, rdata, rresp, rlast, ruser all 0.
  - Both FSMs in IDLE.
- After rst_n deasserts, an init flop sets on the first rising edge. awready and arready are gated by this flop, so they first rise one cycle after release.
- Write latency:
  - AW handshake at edge t → wready=1 from t+1.
  - Final W handshake at t → bvalid=1 from t+1.
  - B handshake at t → awready=1 from t+1.
- Read latency:
  - AR handshake at t → rvalid=1 from t+2.
  - Each non-last R handshake at t → next rvalid from t+2. Sustained rate is one beat per 2 cycles.
  - Last R handshake at t → arready=1 from t+1.
- awready is 0 outside W_IDLE; arready is 0 outside R_IDLE. No second burst is accepted until the current response completes.
- Write and read FSMs advance in the same cycle without interaction.
- awlen=0 / arlen=0 are single-beat bursts. awlen=255 is a 256-beat burst, and its counter must not wrap before the compare.
- Reset mid-burst: both FSMs return to IDLE immediately. Pending B/R responses are discarded. Words already written stay written.
- Backpressure: bvalid/rvalid never deassert without a handshake.

## Test plan
- Reset release: hold rst_n=0 for 5 cycles → all outputs 0. Release → awready=arready=1 exactly one cycle later.
- Single write then read at addr 0x40, data pattern 0xA5.., strb all ones:
  - bresp=00 and bid=awid, one cycle after the W handshake.
  - AR at 0x40 → rvalid two cycles after the AR handshake, rdata=pattern, rlast=1, rresp=00.
- Byte strobes:
  - Write 0xFF.. to word 3.
  - Write 0x00.. with strb=64'h0000_0000_0000_00F0.
  - Read word 3 → bytes 4-7 are 0x00, all others 0xFF.
- 256-beat burst:
  - awlen=255 from word 0, data = beat index.
  - arlen=255 read → 256 beats, rdata[7:0]=0..255, rlast only on beat 255.
  - rready toggled randomly → no beat is dropped or duplicated.
- Range error, LOG_DEPTH=10:
  - 4-beat write starting at word 1022 → words 1022 and 1023 are written, beats 2-3 are dropped, bresp=10.
  - Matching read → resp 00, 00, 10, 10; data of beats 2-3 = 0.
- Concurrency and reset:
  - Overlapping write and read bursts complete independently with the correct IDs.
  - Asserting rst_n=0 during a read's R_DATA → rvalid=0 immediately. After release, a new AR is accepted normally.
